hazard_ctrl: RTL and testbench

Decode-stage hazard controller driving the stall and bubble controls of the ID/EX pipeline register. It tracks in-flight register writes in EX, MEM and WB with a 3-entry scoreboard shift register. When a decoded source register is still pending, it stalls PC and IF/ID and asserts `zero_control_signals`. It also flushes wrong-path instructions on EX redirects and latches halt.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_scoreboard.sv | 65 ++++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

    localparam int SB_DEPTH = 3;
    localparam int REG_W    = 3;

    // One in-flight register write: valid, destination register, is-a-load.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rnum;
        logic             ld;
    } sb_entry_t;

    // True when the entry holds a pending write to register r.
    function automatic logic entry_match(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.v && (e.rnum == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and the hazard controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_rs_valid;
    logic             id_rt_valid;
    logic [2:0]       id_write_reg;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_halt;
    logic             ex_redirect;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             zero_control_signals;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_rs_valid, id_rt_valid, id_write_reg,
               id_reg_write, id_mem_read, id_halt, ex_redirect,
        input  stall_pc, stall_ifid, flush_ifid, zero_control_signals,
               halted, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_rs_valid, id_rt_valid, id_write_reg,
               id_reg_write, id_mem_read, id_halt, ex_redirect,
        output stall_pc, stall_ifid, flush_ifid, zero_control_signals,
               halted, stall_cycles
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB write-tracking shift register with two source-match ports.
// Build option HAZARD_FWD_EN: only a load sitting in EX can cause a hit
// (load-use); older entries still shift for debug visibility.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  sb_entry_t        push_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    output logic             rs_hit_o,
    output logic             rt_hit_o
);

    sb_entry_t sb_q [DEPTH];
    sb_entry_t sb_d [DEPTH];

    // Next state: EX takes the push value, each older stage takes its younger neighbour.
    always_comb begin
        sb_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // Scoreboard register; reset empties every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // Source matching against pending writes.
    always_comb begin
        rs_hit_o = 1'b0;
        rt_hit_o = 1'b0;
`ifdef HAZARD_FWD_EN
        rs_hit_o = entry_match(sb_q[0], rs_i) & sb_q[0].ld;
        rt_hit_o = entry_match(sb_q[0], rt_i) & sb_q[0].ld;
`else
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_match(sb_q[i], rs_i)) begin
                rs_hit_o = 1'b1;
            end else begin
                rs_hit_o = rs_hit_o;
            end
            if (entry_match(sb_q[i], rt_i)) begin
                rt_hit_o = 1'b1;
            end else begin
                rt_hit_o = rt_hit_o;
            end
        end
`endif
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: stall/bubble/flush priority, sticky halt
// latch and saturating stall counter. Honours build option HAZARD_FWD_EN
// (inside hazard_scoreboard).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int SB_DEPTH = hazard_pkg::SB_DEPTH,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_if.slave      bus
);

    logic             rs_hit_s;
    logic             rt_hit_s;
    logic             hazard_s;
    logic             stall_s;
    logic             flush_s;
    logic             zero_s;
    sb_entry_t        push_s;
    logic             halted_q;
    logic             halted_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    hazard_scoreboard #(
        .DEPTH (SB_DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push_s),
        .rs_i     (bus.id_rs),
        .rt_i     (bus.id_rt),
        .rs_hit_o (rs_hit_s),
        .rt_hit_o (rt_hit_s)
    );

    assign hazard_s = ((rs_hit_s & bus.id_rs_valid) | (rt_hit_s & bus.id_rt_valid))
                      & ~bus.ex_redirect & ~halted_q;

    // Priority: reset silences everything, then halt, redirect, hazard.
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        zero_s  = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else if (halted_q) begin
            stall_s = 1'b1;
            zero_s  = 1'b1;
        end else if (bus.ex_redirect) begin
            flush_s = 1'b1;
            zero_s  = 1'b1;
        end else if (hazard_s) begin
            stall_s = 1'b1;
            zero_s  = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Bubbled instructions must not leave a pending write behind.
    always_comb begin
        push_s.v    = bus.id_reg_write & ~zero_s;
        push_s.rnum = bus.id_write_reg;
        push_s.ld   = bus.id_mem_read & ~zero_s;
    end

    // Halt latch and counter next state; a halt on a squashed or stalled
    // instruction is ignored.
    always_comb begin
        halted_d = halted_q | (bus.id_halt & ~hazard_s & ~bus.ex_redirect);
        cnt_d    = cnt_q;
        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sticky halt flag and stall counter; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stall_pc             = stall_s;
    assign bus.stall_ifid           = stall_s;
    assign bus.flush_ifid           = flush_s;
    assign bus.zero_control_signals = zero_s;
    assign bus.halted               = halted_q;
    assign bus.stall_cycles         = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues one decode vector per
// cycle and queues the hand-computed response; a negedge monitor checks it.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        sp;
        logic        fl;
        logic        hlt;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t exp_q [$];
    logic        exp_hlt;
    logic [15:0] exp_cnt;

    hazard_ctrl_if #(.CNT_W(16)) hif ();
    hazard_ctrl_if #(.CNT_W(4))  hif2 ();

    hazard_ctrl #(.SB_DEPTH(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    hazard_ctrl #(.SB_DEPTH(3), .CNT_W(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (hif2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Monitor: check the queued response for the vector driven this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (hif.stall_pc !== e.sp || hif.stall_ifid !== e.sp || hif.flush_ifid !== e.fl ||
                hif.zero_control_signals !== (e.sp | e.fl) || hif.halted !== e.hlt ||
                hif.stall_cycles !== e.cnt) begin
                n_fail++;
                $display("FAIL vec@%0t: got sp=%b sif=%b fl=%b z=%b h=%b cnt=%0d want sp=%b fl=%b z=%b h=%b cnt=%0d",
                         $time, hif.stall_pc, hif.stall_ifid, hif.flush_ifid, hif.zero_control_signals,
                         hif.halted, hif.stall_cycles, e.sp, e.fl, e.sp | e.fl, e.hlt, e.cnt);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic [2:0] rs, input logic rsv, input logic [2:0] rt, input logic rtv,
                       input logic [2:0] wr, input logic rw, input logic mr, input logic halt,
                       input logic redir, input logic e_sp, input logic e_fl);
        exp_t e;
        @(posedge clk);
        #1;
        hif.id_rs = rs;        hif.id_rs_valid = rsv;
        hif.id_rt = rt;        hif.id_rt_valid = rtv;
        hif.id_write_reg = wr; hif.id_reg_write = rw;
        hif.id_mem_read = mr;  hif.id_halt = halt;
        hif.ex_redirect = redir;
        e.sp = e_sp; e.fl = e_fl; e.hlt = exp_hlt; e.cnt = exp_cnt;
        exp_q.push_back(e);
        if (e_sp) exp_cnt = exp_cnt + 16'd1;
        if (halt && !redir && !e_sp && !exp_hlt) exp_hlt = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_hlt, 1'b0);
        end
    endtask

    // Producer of r, `gaps` independent instructions, then a consumer.
    task automatic dep(input logic [2:0] r, input logic ld, input int gaps,
                       input logic use_rt, input int stalls);
        logic [2:0] crs;
        logic [2:0] crt;
        crs = use_rt ? 3'd0 : r;
        crt = use_rt ? r : 3'd0;
        cyc(3'd0, 1'b0, 3'd0, 1'b0, r, 1'b1, ld, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(gaps);
        for (int i = 0; i < stalls; i++) begin
            cyc(crs, ~use_rt, crt, use_rt, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(crs, ~use_rt, crt, use_rt, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left want 0", exp_q.size());
        end
        @(posedge clk);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        exp_hlt = 1'b0; exp_cnt = 16'd0;
        hif.id_rs = 3'd0; hif.id_rt = 3'd0; hif.id_rs_valid = 1'b0; hif.id_rt_valid = 1'b0;
        hif.id_write_reg = 3'd0; hif.id_reg_write = 1'b0; hif.id_mem_read = 1'b0;
        hif.id_halt = 1'b0; hif.ex_redirect = 1'b1;
        hif2.id_rs = 3'd0; hif2.id_rt = 3'd0; hif2.id_rs_valid = 1'b0; hif2.id_rt_valid = 1'b0;
        hif2.id_write_reg = 3'd0; hif2.id_reg_write = 1'b0; hif2.id_mem_read = 1'b0;
        hif2.id_halt = 1'b0; hif2.ex_redirect = 1'b0;
        rst = 1'b1;
        #12;
        // Outputs silent during reset even with a redirect present.
        check("rst_flush", {15'd0, hif.flush_ifid}, 16'd0);
        check("rst_zero", {15'd0, hif.zero_control_signals}, 16'd0);
        check("rst_stall", {15'd0, hif.stall_pc}, 16'd0);
        check("rst_halted", {15'd0, hif.halted}, 16'd0);
        check("rst_cnt", hif.stall_cycles, 16'd0);
        hif.ex_redirect = 1'b0;
        #4;
        rst = 1'b0;

        // Small-counter instance halts and then stalls for the rest of the run.
        @(posedge clk); #1; hif2.id_halt = 1'b1;
        @(posedge clk); #1; hif2.id_halt = 1'b0;

        dep(3'd1, 1'b0, 0, 1'b0, FWD ? 0 : 3);
        dep(3'd2, 1'b1, 0, 1'b1, FWD ? 1 : 3);
        dep(3'd3, 1'b0, 2, 1'b0, FWD ? 0 : 1);
        dep(3'd3, 1'b0, 3, 1'b0, 0);
        dep(3'd4, 1'b1, 1, 1'b1, FWD ? 0 : 2);
        dep(3'd0, 1'b0, 0, 1'b0, FWD ? 0 : 3);

        // Matching register but source not read: no stall.
        cyc(3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3'd7, 1'b0, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Redirect beats a pending hazard; squashed write to r6 is not tracked.
        cyc(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Halt on a redirected cycle is discarded.
        cyc(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Real halt: stalls from the next cycle onward.
        cyc(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        drain();

        check("sat_cnt", {12'd0, hif2.stall_cycles}, 16'd15);
        check("sat_halted", {15'd0, hif2.halted}, 16'd1);

        // Asynchronous reset mid-cycle clears everything immediately.
        #3;
        rst = 1'b1;
        #1;
        check("arst_halted", {15'd0, hif.halted}, 16'd0);
        check("arst_stall", {15'd0, hif.stall_pc}, 16'd0);
        check("arst_zero", {15'd0, hif.zero_control_signals}, 16'd0);
        check("arst_cnt", hif.stall_cycles, 16'd0);
        check("arst_cnt2", {12'd0, hif2.stall_cycles}, 16'd0);
        #10;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
